// File: rtl/regfile_wr_if.sv
// Write-request handshake bundle between a requester and the register-file write port.
interface regfile_wr_if #(
    parameter int WIDTH = 64
);
    logic             wr_valid;
    logic             wr_ready;
    logic [2:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_port.sv
// Write side of an 8-entry register file: a 2-deep in-order request queue that
// commits one entry per cycle into the register array.
module regfile_write_port #(
    parameter int          WIDTH       = 64,
    parameter bit          ZERO_REG_EN = 1'b1,
    parameter int unsigned ZERO_IDX    = 7
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wr_if.slave        wr,
    input  logic               stall,
    output logic [8*WIDTH-1:0] regs_flat,
    output logic [7:0]         wen_onehot,
    output logic [1:0]         pending
);

    typedef struct packed {
        logic [2:0]       addr;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t           queue [2];
    logic [1:0]       count;
    logic [WIDTH-1:0] regs [8];

    logic       accept;
    logic       commit;
    logic       zero_hit;
    logic [1:0] tail;

    // Ready is a pure function of queue occupancy; stall only gates the pop side.
    assign wr.wr_ready = (count != 2'd2) && !reset;
    assign pending     = count;

    always_comb begin
        accept   = wr.wr_valid && wr.wr_ready;
        commit   = (count != 2'd0) && !stall;
        zero_hit = ZERO_REG_EN && (queue[0].addr == 3'(ZERO_IDX));
        // A simultaneous pop shifts the queue down, so the new tail slot moves with it.
        tail     = count - {1'b0, commit};
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let the shift and the tail write race.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 2'd0;
            wen_onehot <= 8'd0;
            queue[0]   <= '0;
            queue[1]   <= '0;
            // NOTE: the register array is reset explicitly because software may
            // read any register before its first write and must see zero.
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            count      <= 2'(count + {1'b0, accept} - {1'b0, commit});
            wen_onehot <= 8'd0;

            if (commit) begin
                queue[0] <= queue[1];
                if (!zero_hit) begin
                    regs[queue[0].addr] <= queue[0].data;
                    wen_onehot          <= 8'd1 << queue[0].addr;
                end
            end

            if (accept) begin
                queue[tail[0]] <= '{addr: wr.wr_addr, data: wr.wr_data};
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            regs_flat[i*WIDTH +: WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_regfile_write_port.sv
// Directed self-checking bench for regfile_write_port: reset, latency, stall/full,
// streaming, zero register and reset-flush behaviour.
module tb_regfile_write_port;

    localparam int WIDTH = 64;

    logic               clk = 1'b0;
    logic               reset;
    logic               stall;
    logic [8*WIDTH-1:0] regs_flat;
    logic [7:0]         wen_onehot;
    logic [1:0]         pending;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_wr_if #(.WIDTH(WIDTH)) wr_bus ();

    regfile_write_port #(.WIDTH(WIDTH), .ZERO_REG_EN(1'b1), .ZERO_IDX(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr         (wr_bus),
        .stall      (stall),
        .regs_flat  (regs_flat),
        .wen_onehot (wen_onehot),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] reg_at(input int idx);
        return regs_flat[idx*WIDTH +: WIDTH];
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [2:0] addr, input logic [63:0] data);
        wr_bus.wr_valid = valid;
        wr_bus.wr_addr  = addr;
        wr_bus.wr_data  = data;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        drive(1'b0, 3'd0, 64'd0);

        // 1: reset held with a request pending on the bus
        drive(1'b1, 3'd2, 64'h55);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_ready", 64'(wr_bus.wr_ready), 64'd0);
            check("rst_pending", 64'(pending), 64'd0);
            check("rst_wen", 64'(wen_onehot), 64'd0);
        end
        for (int i = 0; i < 8; i++) check("rst_reg", reg_at(i), 64'd0);
        drive(1'b0, 3'd0, 64'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", 64'(wr_bus.wr_ready), 64'd1);

        // 2: single write, one-cycle commit latency
        drive(1'b1, 3'd3, 64'hDEAD_BEEF);
        step();
        drive(1'b0, 3'd0, 64'd0);
        check("w3_pending_accept", 64'(pending), 64'd1);
        check("w3_not_yet", reg_at(3), 64'd0);
        check("w3_wen_accept", 64'(wen_onehot), 64'd0);
        step();
        check("w3_reg", reg_at(3), 64'hDEAD_BEEF);
        check("w3_wen", 64'(wen_onehot), 64'h08);
        check("w3_pending_commit", 64'(pending), 64'd0);
        step();
        check("w3_wen_idle", 64'(wen_onehot), 64'd0);

        // 3: stall fills the queue, third request held, then ordered drain
        stall = 1'b1;
        drive(1'b1, 3'd1, 64'hA);
        step();
        check("st_pending1", 64'(pending), 64'd1);
        drive(1'b1, 3'd2, 64'hB);
        step();
        check("st_pending2", 64'(pending), 64'd2);
        drive(1'b1, 3'd5, 64'hC);
        check("st_full_ready", 64'(wr_bus.wr_ready), 64'd0);
        step();
        check("st_held_pending", 64'(pending), 64'd2);
        check("st_held_ready", 64'(wr_bus.wr_ready), 64'd0);
        check("st_no_commit", reg_at(1), 64'd0);
        stall = 1'b0;
        #1;
        check("st_ready_ignores_stall", 64'(wr_bus.wr_ready), 64'd0);
        step();
        check("st_c1_wen", 64'(wen_onehot), 64'h02);
        check("st_c1_reg", reg_at(1), 64'hA);
        check("st_c1_pending", 64'(pending), 64'd1);
        check("st_c1_reg2_untouched", reg_at(2), 64'd0);
        step();
        drive(1'b0, 3'd0, 64'd0);
        check("st_c2_wen", 64'(wen_onehot), 64'h04);
        check("st_c2_reg", reg_at(2), 64'hB);
        check("st_c2_pending", 64'(pending), 64'd1);
        step();
        check("st_c5_wen", 64'(wen_onehot), 64'h20);
        check("st_c5_reg", reg_at(5), 64'hC);
        check("st_c5_pending", 64'(pending), 64'd0);

        // 4: back-to-back stream into the same address
        for (int v = 1; v <= 8; v++) begin
            drive(1'b1, 3'd4, 64'(v));
            #1;
            check("bb_ready", 64'(wr_bus.wr_ready), 64'd1);
            step();
            check("bb_pending", 64'(pending), 64'd1);
            if (v > 1) check("bb_reg4", reg_at(4), 64'(v - 1));
        end
        drive(1'b0, 3'd0, 64'd0);
        step();
        check("bb_final_reg4", reg_at(4), 64'd8);
        check("bb_final_wen", 64'(wen_onehot), 64'h10);
        check("bb_final_pending", 64'(pending), 64'd0);

        // 5: write to the hardwired-zero register is popped but dropped
        drive(1'b1, 3'd7, '1);
        step();
        drive(1'b0, 3'd0, 64'd0);
        check("z_pending_accept", 64'(pending), 64'd1);
        step();
        check("z_pending_pop", 64'(pending), 64'd0);
        check("z_wen", 64'(wen_onehot), 64'd0);
        check("z_reg7", reg_at(7), 64'd0);
        check("z_reg3_kept", reg_at(3), 64'hDEAD_BEEF);

        // 6: reset while the queue is full discards the queued entries
        stall = 1'b1;
        drive(1'b1, 3'd0, 64'h11);
        step();
        drive(1'b1, 3'd6, 64'h22);
        step();
        drive(1'b0, 3'd0, 64'd0);
        check("rf_pending_full", 64'(pending), 64'd2);
        reset = 1'b1;
        step();
        check("rf_pending", 64'(pending), 64'd0);
        check("rf_ready", 64'(wr_bus.wr_ready), 64'd0);
        for (int i = 0; i < 8; i++) check("rf_reg", reg_at(i), 64'd0);
        reset = 1'b0;
        stall = 1'b0;
        step();
        step();
        check("rf_post_pending", 64'(pending), 64'd0);
        check("rf_post_wen", 64'(wen_onehot), 64'd0);
        check("rf_post_reg0", reg_at(0), 64'd0);
        check("rf_post_reg6", reg_at(6), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
